// File: rtl/sw_feeder.sv
// Presents one byte at a time on a CPU switch bus. Each byte gets a one-cycle
// setup, a HOLD_CYCLES-long strobe pulse and a GAP_CYCLES-long idle gap.
module sw_feeder #(
   parameter int n           = 8,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 16
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [n-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [n:0]   sw_out,
   output logic         busy,
   output logic [7:0]   byte_count
);

   typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

   state_t       state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [n-1:0] data_q, data_d;
   logic         strobe_q, strobe_d;
   logic [7:0]   count_q, count_d;

   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign sw_out     = {strobe_q, data_q};
   assign byte_count = count_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      strobe_d = strobe_q;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            strobe_d = 1'b0;
            if (in_valid) begin
               data_d  = in_data;
               state_d = SETUP;
            end
         end
         SETUP: begin
            strobe_d = 1'b1;
            cnt_d    = HOLD_LOAD;
            state_d  = HOLD;
         end
         HOLD: begin
            // The byte only counts once its full strobe pulse has been shown.
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               strobe_d = 1'b0;
               cnt_d    = GAP_LOAD;
               count_d  = count_q + 8'd1;
               state_d  = GAP;
            end
         end
         GAP: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         count_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_sw_feeder.sv
// Directed bench for sw_feeder: HOLD=4/GAP=3 instance plus a HOLD=1/GAP=1 instance.
module tb_sw_feeder;

   logic       clk = 1'b0;
   logic       n_reset;
   logic [7:0] in_data, in_data_m;
   logic       in_valid, in_valid_m;
   logic       in_ready, in_ready_m;
   logic [8:0] sw_out, sw_out_m;
   logic       busy, busy_m;
   logic [7:0] byte_count, byte_count_m;

   int tests = 0;
   int fails = 0;
   int run, bad, nbytes;

   always #5 clk = ~clk;

   sw_feeder #(.n(8), .HOLD_CYCLES(4), .GAP_CYCLES(3)) dut (
      .clk(clk), .n_reset(n_reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .sw_out(sw_out), .busy(busy), .byte_count(byte_count)
   );

   sw_feeder #(.n(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_min (
      .clk(clk), .n_reset(n_reset), .in_data(in_data_m), .in_valid(in_valid_m),
      .in_ready(in_ready_m), .sw_out(sw_out_m), .busy(busy_m), .byte_count(byte_count_m)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called with the DUT in SETUP; walks HOLD, GAP and the return to IDLE.
   task automatic pulse(input logic [7:0] d, input bit toggle, input logic [7:0] exp_cnt);
      for (int i = 0; i < 4; i++) begin
         if (toggle) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
         end
         tick;
         chk("hold_sw", 16'(sw_out), {7'd0, 1'b1, d});
         chk("hold_ready", 16'(in_ready), 16'd0);
      end
      for (int i = 0; i < 3; i++) begin
         if (toggle) in_data = 8'($urandom);
         tick;
         chk("gap_sw", 16'(sw_out), {7'd0, 1'b0, d});
         chk("gap_busy", 16'(busy), 16'd1);
      end
      tick;
      chk("idle_sw", 16'(sw_out), {7'd0, 1'b0, d});
      chk("idle_ready", 16'(in_ready), 16'd1);
      chk("idle_count", 16'(byte_count), 16'(exp_cnt));
   endtask

   initial begin
      n_reset    = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      in_valid_m = 1'b0;
      in_data_m  = 8'h00;
      tick;
      tick;
      chk("rst_sw", 16'(sw_out), 16'h000);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_count", 16'(byte_count), 16'd0);
      chk("rst_ready", 16'(in_ready), 16'd1);

      // valid during reset must not be taken
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick;
      chk("rst_notake_sw", 16'(sw_out), 16'h000);
      chk("rst_notake_busy", 16'(busy), 16'd0);
      in_valid = 1'b0;
      n_reset  = 1'b1;
      tick;
      chk("idle_busy", 16'(busy), 16'd0);

      // reset on the 2nd strobe-high cycle of the first byte
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick;
      in_valid = 1'b0;
      chk("rm_setup", 16'(sw_out), 16'h05A);
      tick;
      chk("rm_hold1", 16'(sw_out), 16'h15A);
      tick;
      chk("rm_hold2", 16'(sw_out), 16'h15A);
      n_reset = 1'b0;
      tick;
      n_reset = 1'b1;
      chk("rm_sw", 16'(sw_out), 16'h000);
      chk("rm_busy", 16'(busy), 16'd0);
      chk("rm_count", 16'(byte_count), 16'd0);
      tick;
      chk("rm_idle_count", 16'(byte_count), 16'd0);

      // single byte
      in_valid = 1'b1;
      in_data  = 8'hA5;
      tick;
      in_valid = 1'b0;
      in_data  = 8'h00;
      chk("sb_setup", 16'(sw_out), 16'h0A5);
      chk("sb_setup_ready", 16'(in_ready), 16'd0);
      pulse(8'hA5, 1'b0, 8'd1);

      // back-to-back with valid held high
      in_valid = 1'b1;
      in_data  = 8'h11;
      tick;
      in_data  = 8'h22;
      chk("b2b_setup1", 16'(sw_out), 16'h011);
      pulse(8'h11, 1'b0, 8'd2);
      tick;
      chk("b2b_setup2", 16'(sw_out), 16'h022);
      chk("b2b_busy2", 16'(busy), 16'd1);
      in_valid = 1'b0;
      pulse(8'h22, 1'b0, 8'd3);

      // input churn while busy is ignored
      in_valid = 1'b1;
      in_data  = 8'h3C;
      tick;
      chk("ign_setup", 16'(sw_out), 16'h03C);
      pulse(8'h3C, 1'b1, 8'd4);
      in_valid = 1'b0;
      tick;
      chk("ign_count", 16'(byte_count), 16'd4);
      chk("ign_idle", 16'(busy), 16'd0);

      // 256 bytes back-to-back: counter wraps, every strobe is 4 cycles
      n_reset = 1'b0;
      tick;
      n_reset  = 1'b1;
      in_valid = 1'b1;
      run = 0;
      bad = 0;
      nbytes = 0;
      for (int k = 0; k < 256 * 9; k++) begin
         in_data = 8'(k);
         tick;
         if (sw_out[8]) begin
            run++;
         end else if (run != 0) begin
            if (run != 4) bad++;
            nbytes++;
            run = 0;
            if (nbytes == 255) chk("wrap_255", 16'(byte_count), 16'd255);
         end
      end
      in_valid = 1'b0;
      chk("wrap_nbytes", 16'(nbytes), 16'd256);
      chk("wrap_badhigh", 16'(bad), 16'd0);
      chk("wrap_count", 16'(byte_count), 16'd0);

      // minimum parameters: 1 setup + 1 hold + 1 gap + 1 idle = 4-cycle period
      in_valid_m = 1'b1;
      in_data_m  = 8'hC3;
      tick;
      chk("min_setup", 16'(sw_out_m), 16'h0C3);
      tick;
      chk("min_hold", 16'(sw_out_m), 16'h1C3);
      tick;
      chk("min_gap", 16'(sw_out_m), 16'h0C3);
      chk("min_count", 16'(byte_count_m), 16'd1);
      tick;
      chk("min_ready", 16'(in_ready_m), 16'd1);
      in_data_m = 8'h3C;
      tick;
      chk("min_next_sw", 16'(sw_out_m), 16'h03C);
      chk("min_next_busy", 16'(busy_m), 16'd1);
      in_valid_m = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
